alu_shift_unit: RTL and testbench

// Datapath arithmetic stage that sits directly downstream of the control FSM on the shared 16-bit bus.

---
 rtl/alu_shift_unit_if.sv | 28 ++
 rtl/alu_shift_unit.sv | 184 ++++++++++++++++++
 tb/tb_alu_shift_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_shift_unit_if.sv
// Controller-facing bus of the ALU/shift stage: operand bus, control strobes and results.
// The controller side uses the master modport; the datapath stage uses slave.
interface alu_shift_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] bus_in;
  logic [3:0]       aluSel;
  logic [2:0]       shiftSel;
  logic             workregWr;
  logic             outRegWr;
  logic             outRegRd;
  logic [2:0]       cmpSel;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic [3:0]       flags;
  logic             cmp_true;
  logic             busy;

  modport master (
    output bus_in, aluSel, shiftSel, workregWr, outRegWr, outRegRd, cmpSel,
    input  bus_out, bus_oe, flags, cmp_true, busy
  );

  modport slave (
    input  bus_in, aluSel, shiftSel, workregWr, outRegWr, outRegRd, cmpSel,
    output bus_out, bus_oe, flags, cmp_true, busy
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Datapath arithmetic stage: working register, ALU -> shifter into the output buffer,
// {N,Z,C,V} flags with a signed compare, and a 16-cycle shift-add multiplier.
module alu_shift_unit #(
  parameter int unsigned WIDTH = 16
) (
  input logic              clock,
  input logic              reset,
  alu_shift_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             r_state, w_state_next;
  logic [WIDTH-1:0]   r_workreg, w_workreg_next;
  logic [WIDTH-1:0]   r_outreg, w_outreg_next;
  logic [3:0]         r_flags, w_flags_next;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_next;
  logic [WIDTH-1:0]   r_mplier, w_mplier_next;
  logic [2*WIDTH-1:0] r_acc, w_acc_next;
  logic [CntW-1:0]    r_cnt, w_cnt_next;

  logic [WIDTH-1:0]   w_a, w_b;
  logic [WIDTH:0]     w_sum, w_diff, w_inc, w_dec;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c, w_alu_v;
  logic [WIDTH:0]     w_sh;
  logic [2*WIDTH-1:0] w_acc_add;
  logic [WIDTH:0]     w_mul_sh;
  logic               w_n, w_z, w_v;

  // Returns {carry, result}; a pass shift keeps the incoming carry.
  function automatic logic [WIDTH:0] shift_f(input logic [WIDTH-1:0] r,
                                             input logic [2:0]       sel,
                                             input logic             c_in);
    logic [WIDTH:0] o;
    case (sel)
      3'd1:    o = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
      3'd2:    o = {r[0], 1'b0, r[WIDTH-1:1]};
      3'd3:    o = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
      3'd4:    o = {r[0], r[0], r[WIDTH-1:1]};
      default: o = {c_in, r};
    endcase
    return o;
  endfunction

  assign w_a    = r_workreg;
  assign w_b    = bus.bus_in;
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_inc  = {1'b0, w_b} + (WIDTH+1)'(1);
  assign w_dec  = {1'b0, w_b} - (WIDTH+1)'(1);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.aluSel)
      4'd0: w_alu_res = w_b;
      4'd1: w_alu_res = w_a & w_b;
      4'd2: w_alu_res = w_a | w_b;
      4'd3: w_alu_res = ~w_b;
      4'd4: w_alu_res = w_a ^ w_b;
      4'd5: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      4'd6: begin
        // Upper bit of the extended difference is the unsigned borrow (A < B).
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      4'd7: begin
        w_alu_res = w_inc[WIDTH-1:0];
        w_alu_c   = w_inc[WIDTH];
        w_alu_v   = !w_b[WIDTH-1] && w_inc[WIDTH-1];
      end
      4'd8: begin
        w_alu_res = w_dec[WIDTH-1:0];
        w_alu_c   = w_dec[WIDTH];
        w_alu_v   = w_b[WIDTH-1] && !w_dec[WIDTH-1];
      end
      default: w_alu_res = '0;
    endcase
  end

  assign w_sh      = shift_f(w_alu_res, bus.shiftSel, w_alu_c);
  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_sh  = shift_f(w_acc_add[WIDTH-1:0], bus.shiftSel, 1'b0);

  always_comb begin
    w_state_next   = r_state;
    w_workreg_next = r_workreg;
    w_outreg_next  = r_outreg;
    w_flags_next   = r_flags;
    w_mcand_next   = r_mcand;
    w_mplier_next  = r_mplier;
    w_acc_next     = r_acc;
    w_cnt_next     = r_cnt;

    // workreg loads in every state; outReg sees the pre-edge value when both strobe together.
    if (bus.workregWr) begin
      w_workreg_next = bus.bus_in;
    end

    case (r_state)
      StIdle: begin
        if (bus.outRegWr) begin
          if (bus.aluSel == 4'd10) begin
            w_mcand_next  = {{WIDTH{1'b0}}, w_a};
            w_mplier_next = w_b;
            w_acc_next    = '0;
            w_cnt_next    = '0;
            w_state_next  = StMul;
          end else begin
            w_outreg_next = w_sh[WIDTH-1:0];
            w_flags_next  = {w_sh[WIDTH-1], (w_sh[WIDTH-1:0] == '0), w_sh[WIDTH], w_alu_v};
          end
        end
      end
      StMul: begin
        w_acc_next    = w_acc_add;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + CntW'(1);
        if (r_cnt == CntW'(WIDTH - 1)) begin
          w_outreg_next = w_mul_sh[WIDTH-1:0];
          w_flags_next  = {w_mul_sh[WIDTH-1], (w_mul_sh[WIDTH-1:0] == '0), w_mul_sh[WIDTH],
                           (w_acc_add[2*WIDTH-1:WIDTH] != '0)};
          w_state_next  = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_workreg <= '0;
      r_outreg  <= '0;
      r_flags   <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_workreg <= w_workreg_next;
      r_outreg  <= w_outreg_next;
      r_flags   <= w_flags_next;
      r_mcand   <= w_mcand_next;
      r_mplier  <= w_mplier_next;
      r_acc     <= w_acc_next;
      r_cnt     <= w_cnt_next;
    end
  end

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_v = r_flags[0];

  always_comb begin
    bus.cmp_true = 1'b0;
    case (bus.cmpSel)
      3'd0:    bus.cmp_true = w_z;
      3'd1:    bus.cmp_true = !w_z;
      3'd2:    bus.cmp_true = !w_z && (w_n == w_v);
      3'd3:    bus.cmp_true = (w_n == w_v);
      3'd4:    bus.cmp_true = (w_n != w_v);
      3'd5:    bus.cmp_true = w_z || (w_n != w_v);
      default: bus.cmp_true = 1'b0;
    endcase
  end

  assign bus.bus_out = bus.outRegRd ? r_outreg : '0;
  assign bus.bus_oe  = bus.outRegRd;
  assign bus.flags   = r_flags;
  assign bus.busy    = (r_state == StMul);

endmodule

// File: tb/tb_alu_shift_unit.sv
// Directed-vector bench: reads push expected {data, flags, cmp} into a queue and a
// monitor pops/compares whenever the unit drives the bus (bus_oe).
module tb_alu_shift_unit;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [3:0]  flags;
    logic        cmp;
  } exp_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  alu_shift_unit_if #(.WIDTH(16)) bus_if ();

  alu_shift_unit #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus_if.bus_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got bus_out %h expected no read", bus_if.bus_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".data"}, 32'(bus_if.bus_out), 32'(e.data));
        chk({e.name, ".flags"}, 32'(bus_if.flags), 32'(e.flags));
        chk({e.name, ".cmp"}, 32'(bus_if.cmp_true), 32'(e.cmp));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_wr(input logic [15:0] v);
    bus_if.bus_in    = v;
    bus_if.workregWr = 1'b1;
    tick();
    bus_if.workregWr = 1'b0;
  endtask

  task automatic alu_op(input logic [3:0] a, input logic [2:0] s, input logic [15:0] b);
    bus_if.bus_in   = b;
    bus_if.aluSel   = a;
    bus_if.shiftSel = s;
    bus_if.outRegWr = 1'b1;
    tick();
    bus_if.outRegWr = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] cmp, input logic [15:0] d,
                    input logic [3:0] f, input logic c);
    exp_q.push_back('{name, d, f, c});
    bus_if.cmpSel   = cmp;
    bus_if.outRegRd = 1'b1;
    tick();
    bus_if.outRegRd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    errors = 0;
    checks = 0;
    bus_if.bus_in    = '0;
    bus_if.aluSel    = '0;
    bus_if.shiftSel  = '0;
    bus_if.workregWr = 1'b0;
    bus_if.outRegWr  = 1'b0;
    bus_if.outRegRd  = 1'b0;
    bus_if.cmpSel    = '0;
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_flags", 32'(bus_if.flags), 32'h0);
    chk("rst_busy", 32'(bus_if.busy), 32'h0);
    chk("rst_oe", 32'(bus_if.bus_oe), 32'h0);
    chk("rst_bus", 32'(bus_if.bus_out), 32'h0);
    reset = 1'b0;
    tick();

    alu_op(4'd9, 3'd0, 16'h1234);
    rd("zero", 3'd0, 16'h0000, 4'b0100, 1'b1);

    load_wr(16'h7FFF);
    alu_op(4'd5, 3'd0, 16'h0001);
    chk("no_rd_bus", 32'(bus_if.bus_out), 32'h0);
    rd("plus_ovf", 3'd4, 16'h8000, 4'b1001, 1'b0);

    load_wr(16'h0003);
    alu_op(4'd6, 3'd0, 16'h0005);
    rd("sub_borrow", 3'd4, 16'hFFFE, 4'b1010, 1'b1);

    alu_op(4'd0, 3'd3, 16'h8001);
    rd("rotl", 3'd2, 16'h0003, 4'b0010, 1'b1);
    alu_op(4'd0, 3'd2, 16'h8001);
    rd("shr", 3'd3, 16'h4000, 4'b0010, 1'b1);

    alu_op(4'd7, 3'd0, 16'hFFFF);
    rd("inc_wrap", 3'd0, 16'h0000, 4'b0110, 1'b1);
    alu_op(4'd8, 3'd0, 16'h0000);
    rd("dec_zero", 3'd5, 16'hFFFF, 4'b1010, 1'b1);
    alu_op(4'd8, 3'd0, 16'h8000);
    rd("dec_ovf", 3'd4, 16'h7FFF, 4'b0001, 1'b1);

    alu_op(4'd1, 3'd0, 16'h00F1);
    rd("and", 3'd6, 16'h0001, 4'b0000, 1'b0);
    alu_op(4'd4, 3'd1, 16'h0003);
    rd("xor_shl", 3'd7, 16'h0000, 4'b0100, 1'b0);
    alu_op(4'd12, 3'd0, 16'hABCD);
    rd("sel12", 3'd0, 16'h0000, 4'b0100, 1'b1);
    alu_op(4'd3, 3'd6, 16'h00FF);
    rd("not_sh6", 3'd2, 16'hFF00, 4'b1000, 1'b0);

    // Simultaneous workreg and outReg write: sum uses old workreg 0003.
    bus_if.workregWr = 1'b1;
    alu_op(4'd5, 3'd0, 16'h0010);
    bus_if.workregWr = 1'b0;
    rd("same_cycle", 3'd3, 16'h0013, 4'b0000, 1'b1);
    alu_op(4'd5, 3'd0, 16'h0001);
    rd("new_workreg", 3'd1, 16'h0011, 4'b0000, 1'b1);

    load_wr(16'h0123);
    alu_op(4'd10, 3'd0, 16'h0010);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      if (n == 5) begin
        bus_if.aluSel   = 4'd9;
        bus_if.outRegWr = 1'b1;
      end
      if (n == 8) begin
        exp_q.push_back('{"mul_mid_rd", 16'h0011, 4'b0000, 1'b1});
        bus_if.cmpSel   = 3'd1;
        bus_if.outRegRd = 1'b1;
      end
      tick();
      bus_if.outRegWr = 1'b0;
      bus_if.outRegRd = 1'b0;
      n++;
    end
    chk("mul1_busy_cycles", 32'(n), 32'd16);
    rd("mul1", 3'd4, 16'h1230, 4'b0000, 1'b0);

    load_wr(16'hFFFF);
    alu_op(4'd10, 3'd0, 16'h0002);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      if (n == 4) begin
        bus_if.bus_in    = 16'h0005;
        bus_if.workregWr = 1'b1;
      end
      tick();
      bus_if.workregWr = 1'b0;
      n++;
    end
    chk("mul2_busy_cycles", 32'(n), 32'd16);
    rd("mul2_ovf", 3'd4, 16'hFFFE, 4'b1001, 1'b0);
    alu_op(4'd5, 3'd0, 16'h0001);
    rd("wr_during_mul", 3'd3, 16'h0006, 4'b0000, 1'b1);

    load_wr(16'h0123);
    alu_op(4'd10, 3'd0, 16'h0010);
    repeat (7) tick();
    chk("mid_mul_busy", 32'(bus_if.busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus_if.busy), 32'h0);
    chk("abort_flags", 32'(bus_if.flags), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    rd("abort_outreg", 3'd0, 16'h0000, 4'b0000, 1'b0);
    alu_op(4'd5, 3'd0, 16'h0004);
    rd("post_abort", 3'd1, 16'h0004, 4'b0000, 1'b1);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
